// File: rtl/stereo_block_matcher.sv
// stereo_block_matcher
//   Slides a BLOCK_SIZE x BLOCK_SIZE template along a reference line,
//   accumulating SAD or SSD cost for every compare position. The
//   block arrives one row per beat. After its last row, the block
//   reports the position with the lowest cost (lowest index on ties).
//
// Ports
//   aclk, aresetn             clock, asynchronous active-low reset
//   s_valid / s_ready         input beat handshake
//   line                      one reference row, pixel p at [p*PW +: PW]
//   block                     one template row, pixel j at [j*PW +: PW]
//   first / last              beat is the first / final row of a block
//   block_idx, mode           tag and metric (0=SAD, 1=SSD), taken on first beat
//   m_valid / m_ready         result handshake
//   best_idx, best_cost       winning compare position and its cost
//   m_block_idx               tag of the block the result belongs to
//   err                       one-cycle pulse on an out-of-sequence first flag
module stereo_block_matcher #(
  parameter int FRAME_WIDTH  = 320,
  parameter int BLOCK_SIZE   = 8,
  parameter int COMPARE_STEP = 8,
  parameter int CHAN_BITS    = 8,
  parameter int NUM_CHANNELS = 3,
  parameter int ACC_WIDTH    = 32,
  localparam int PW = NUM_CHANNELS * CHAN_BITS,
  localparam int NC = (FRAME_WIDTH - BLOCK_SIZE) / COMPARE_STEP + 1,
  localparam int CW = (NC > 1) ? $clog2(NC) : 1
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [FRAME_WIDTH*PW-1:0] line,
  input  logic [BLOCK_SIZE*PW-1:0]  block,
  input  logic                      first,
  input  logic                      last,
  input  logic [15:0]               block_idx,
  input  logic                      mode,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [CW-1:0]             best_idx,
  output logic [ACC_WIDTH-1:0]      best_cost,
  output logic [15:0]               m_block_idx,
  output logic                      err
);

  // Row cost is wide enough for BLOCK_SIZE*NUM_CHANNELS squared terms.
  localparam int RW     = 2 * CHAN_BITS + $clog2(BLOCK_SIZE * NUM_CHANNELS + 1);
  localparam int SW     = ((RW > ACC_WIDTH) ? RW : ACC_WIDTH) + 1;
  localparam int STRIDE = COMPARE_STEP * PW;
  localparam logic [CW-1:0]        LAST_C  = CW'(NC - 1);
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;

  typedef enum logic [1:0] {IDLE, COMPUTE, OUTPUT} state_t;

  state_t                    r_state, w_next_state;
  logic [FRAME_WIDTH*PW-1:0] r_line;
  logic [BLOCK_SIZE*PW-1:0]  r_block;
  logic                      r_first, r_last, r_mode, r_open, r_err;
  logic [15:0]               r_tag;
  logic [CW-1:0]             r_c, r_best_idx;
  logic [ACC_WIDTH-1:0]      r_best_cost;
  logic [ACC_WIDTH-1:0]      r_acc [NC];

  logic                      w_hs, w_discard, w_load, w_last_c;
  logic [BLOCK_SIZE*PW-1:0]  w_seg;
  logic [RW-1:0]             w_row;
  logic [SW-1:0]             w_sum;
  logic [ACC_WIDTH-1:0]      w_new;

  function automatic logic [RW-1:0] row_cost(
    input logic [BLOCK_SIZE*PW-1:0] b,
    input logic [BLOCK_SIZE*PW-1:0] l,
    input logic                     ssd
  );
    logic [RW-1:0]          sum;
    logic [CHAN_BITS-1:0]   bv, lv;
    logic [2*CHAN_BITS-1:0] d, t;
    sum = '0;
    for (int j = 0; j < BLOCK_SIZE; j++) begin
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        bv  = b[j*PW + k*CHAN_BITS +: CHAN_BITS];
        lv  = l[j*PW + k*CHAN_BITS +: CHAN_BITS];
        d   = (bv >= lv) ? {{CHAN_BITS{1'b0}}, bv - lv} : {{CHAN_BITS{1'b0}}, lv - bv};
        t   = ssd ? d * d : d;
        sum = sum + RW'(t);
      end
    end
    return sum;
  endfunction

  // Cost of the current compare position, folded into its accumulator.
  always_comb begin
    w_seg = r_line[r_c*STRIDE +: BLOCK_SIZE*PW];
    w_row = row_cost(r_block, w_seg, r_mode);
    w_sum = (r_first ? '0 : SW'(r_acc[r_c])) + SW'(w_row);
    w_new = (w_sum > SW'(ACC_MAX)) ? ACC_MAX : w_sum[ACC_WIDTH-1:0];
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    w_hs         = s_valid && (r_state == IDLE);
    w_discard    = w_hs && !first && !r_open;
    w_load       = w_hs && !w_discard;
    w_last_c     = (r_c == LAST_C);
    w_next_state = r_state;
    s_ready      = 1'b0;
    m_valid      = 1'b0;
    case (r_state)
      IDLE: begin
        s_ready = 1'b1;
        if (w_load) w_next_state = COMPUTE;
      end
      COMPUTE: begin
        if (w_last_c) w_next_state = r_last ? OUTPUT : IDLE;
      end
      OUTPUT: begin
        m_valid = 1'b1;
        if (m_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= IDLE;
      r_c         <= '0;
      r_open      <= 1'b0;
      r_err       <= 1'b0;
      r_first     <= 1'b0;
      r_last      <= 1'b0;
      r_mode      <= 1'b0;
      r_tag       <= '0;
      r_best_idx  <= '0;
      r_best_cost <= '0;
    end else begin
      r_state <= w_next_state;
      // Error when first=0 with no block open, or first=1 with one open.
      r_err   <= w_hs && (first == r_open);
      if (w_load) begin
        r_c     <= '0;
        r_first <= first;
        r_last  <= last;
        r_open  <= 1'b1;
        if (first) begin
          r_mode <= mode;
          r_tag  <= block_idx;
        end
      end
      if (r_state == COMPUTE) begin
        r_c <= r_c + 1'b1;
        // Strict less-than keeps the lowest index on ties.
        if (r_last && (r_c == '0 || w_new < r_best_cost)) begin
          r_best_idx  <= r_c;
          r_best_cost <= w_new;
        end
      end
      if (r_state == OUTPUT && m_ready) r_open <= 1'b0;
    end
  end

  // NOTE: line/block buffers and accumulators are not reset; they are always
  // written before being read, so a reset would only cost routing.
  always_ff @(posedge aclk) begin
    if (w_load) begin
      r_line  <= line;
      r_block <= block;
    end
    if (r_state == COMPUTE) r_acc[r_c] <= w_new;
  end

  assign best_idx    = r_best_idx;
  assign best_cost   = r_best_cost;
  assign m_block_idx = r_tag;
  assign err         = r_err;

endmodule

// File: tb/tb_stereo_block_matcher.sv
module tb_stereo_block_matcher;

  localparam int FW = 32;
  localparam int BS = 4;
  localparam int NC = 8;
  localparam int PW = 24;
  localparam longint MAX32 = 64'd4294967295;

  logic            aclk, aresetn, s_valid, first, last, mode, m_ready;
  logic [FW*PW-1:0] line;
  logic [BS*PW-1:0] blk;
  logic [15:0]     block_idx;
  logic            s_ready, m_valid, err;
  logic [2:0]      best_idx;
  logic [31:0]     best_cost;
  logic [15:0]     m_block_idx;
  logic            s_ready8, m_valid8, err8;
  logic [2:0]      best_idx8;
  logic [7:0]      best_cost8;
  logic [15:0]     m_block_idx8;

  stereo_block_matcher #(
    .FRAME_WIDTH(FW), .BLOCK_SIZE(BS), .COMPARE_STEP(4),
    .CHAN_BITS(8), .NUM_CHANNELS(3), .ACC_WIDTH(32)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .s_valid(s_valid), .s_ready(s_ready),
    .line(line), .block(blk), .first(first), .last(last),
    .block_idx(block_idx), .mode(mode), .m_valid(m_valid), .m_ready(m_ready),
    .best_idx(best_idx), .best_cost(best_cost), .m_block_idx(m_block_idx),
    .err(err)
  );

  // Narrow-accumulator copy sees identical traffic; used for saturation.
  stereo_block_matcher #(
    .FRAME_WIDTH(FW), .BLOCK_SIZE(BS), .COMPARE_STEP(4),
    .CHAN_BITS(8), .NUM_CHANNELS(3), .ACC_WIDTH(8)
  ) dut8 (
    .aclk(aclk), .aresetn(aresetn), .s_valid(s_valid), .s_ready(s_ready8),
    .line(line), .block(blk), .first(first), .last(last),
    .block_idx(block_idx), .mode(mode), .m_valid(m_valid8), .m_ready(m_ready),
    .best_idx(best_idx8), .best_cost(best_cost8), .m_block_idx(m_block_idx8),
    .err(err8)
  );

  typedef struct {
    int          idx;
    longint      cost;
    logic [15:0] tag;
  } exp_t;

  typedef struct {
    int     kind;
    logic   md;
    int     rows;
    int     exp_idx;
    longint exp_cost;
  } vec_t;

  exp_t         sb_q[$];
  vec_t         vecs[7];
  logic [PW-1:0] lp [4][FW];
  logic [PW-1:0] bp [4][BS];
  int           n_checks = 0;
  int           n_errs   = 0;
  int           cyc      = 0;
  int           t_hs     = 0;

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: compare every accepted result against the queued expectation.
  always @(negedge aclk) begin
    if (aresetn && m_valid && m_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", 64'(m_valid), 64'd0);
      end else begin
        exp_t ex;
        ex = sb_q.pop_front();
        check("best_idx", 64'(best_idx), 64'(ex.idx));
        check("best_cost", 64'(best_cost), 64'(ex.cost));
        check("m_block_idx", 64'(m_block_idx), 64'(ex.tag));
      end
    end
  end

  // kind 0: block = line pixels 12..15, rest 0xFFFFFF; 1: line 0, block 0x02;
  // 2: random; 3: block 0xFF, line 0x00.
  task automatic fill(input int kind, input int rows);
    for (int r = 0; r < rows; r++) begin
      for (int p = 0; p < FW; p++) begin
        case (kind)
          0:       lp[r][p] = 24'hFFFFFF;
          2:       lp[r][p] = 24'($urandom);
          default: lp[r][p] = 24'h000000;
        endcase
      end
      for (int j = 0; j < BS; j++) begin
        case (kind)
          0: begin
            lp[r][12+j] = 24'($urandom) & 24'h7F7F7F;
            bp[r][j]    = lp[r][12+j];
          end
          1:       bp[r][j] = 24'h020202;
          2:       bp[r][j] = 24'($urandom);
          default: bp[r][j] = 24'hFFFFFF;
        endcase
      end
    end
  endtask

  task automatic model(input int rows, input logic md, output int bi, output longint bc);
    longint acc [NC];
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < NC; c++) begin
        longint rc;
        rc = 0;
        for (int j = 0; j < BS; j++) begin
          for (int k = 0; k < 3; k++) begin
            int bv, lv, d;
            bv = int'(bp[r][j][k*8 +: 8]);
            lv = int'(lp[r][c*4 + j][k*8 +: 8]);
            d  = (bv > lv) ? bv - lv : lv - bv;
            rc += md ? longint'(d * d) : longint'(d);
          end
        end
        acc[c] = (r == 0) ? rc : acc[c] + rc;
        if (acc[c] > MAX32) acc[c] = MAX32;
      end
    end
    bi = 0;
    bc = acc[0];
    for (int c = 1; c < NC; c++) begin
      if (acc[c] < bc) begin
        bi = c;
        bc = acc[c];
      end
    end
  endtask

  task automatic pack_row(input int r);
    for (int p = 0; p < FW; p++) line[p*PW +: PW] = lp[r][p];
    for (int j = 0; j < BS; j++) blk[j*PW +: PW] = bp[r][j];
  endtask

  // Called at a negedge; returns at the negedge after the handshake, with
  // the err value visible in that cycle.
  task automatic send_beat(input logic f, input logic l, input logic md,
                           input logic [15:0] tag, output logic e);
    int n;
    n = 0;
    while (!s_ready && n < 200) begin
      @(negedge aclk);
      n++;
    end
    if (!s_ready) begin
      check("s_ready_timeout", 64'(s_ready), 64'd1);
      e = 1'bx;
      return;
    end
    first     = f;
    last      = l;
    mode      = md;
    block_idx = tag;
    s_valid   = 1'b1;
    t_hs      = cyc;
    @(negedge aclk);
    s_valid = 1'b0;
    first   = 1'b0;
    last    = 1'b0;
    e       = err;
  endtask

  task automatic run_block(input int rows, input logic md, input logic [15:0] tag,
                           input int ov_idx, input longint ov_cost, input logic err_first);
    int     bi;
    longint bc;
    exp_t   ex;
    logic   e;
    model(rows, md, bi, bc);
    ex.idx  = (ov_idx >= 0) ? ov_idx : bi;
    ex.cost = (ov_idx >= 0) ? ov_cost : bc;
    ex.tag  = tag;
    sb_q.push_back(ex);
    for (int r = 0; r < rows; r++) begin
      pack_row(r);
      if (r == 0) begin
        send_beat(1'b1, rows == 1, md, tag, e);
        check("err_first_beat", 64'(e), 64'(err_first));
      end else begin
        // Non-first beats carry junk mode/tag that must be ignored.
        send_beat(1'b0, r == rows - 1, ~md, 16'($urandom), e);
        check("err_later_beat", 64'(e), 64'd0);
      end
    end
  endtask

  task automatic wait_result(output int lat);
    int n;
    n = 0;
    while (!m_valid && n < 100) begin
      @(negedge aclk);
      n++;
    end
    if (!m_valid) check("m_valid_timeout", 64'(m_valid), 64'd1);
    lat = cyc - t_hs;
  endtask

  initial begin
    int   lat, n;
    logic e, seen;

    aresetn   = 1'b0;
    s_valid   = 1'b0;
    first     = 1'b0;
    last      = 1'b0;
    mode      = 1'b0;
    m_ready   = 1'b1;
    block_idx = '0;
    line      = '0;
    blk       = '0;

    vecs[0] = '{kind: 0, md: 1'b0, rows: 4, exp_idx: 3, exp_cost: 0};
    vecs[1] = '{kind: 1, md: 1'b0, rows: 4, exp_idx: 0, exp_cost: 96};
    vecs[2] = '{kind: 1, md: 1'b1, rows: 4, exp_idx: 0, exp_cost: 192};
    vecs[3] = '{kind: 2, md: 1'b0, rows: 3, exp_idx: -1, exp_cost: 0};
    vecs[4] = '{kind: 2, md: 1'b1, rows: 2, exp_idx: -1, exp_cost: 0};
    vecs[5] = '{kind: 0, md: 1'b1, rows: 1, exp_idx: 3, exp_cost: 0};
    vecs[6] = '{kind: 3, md: 1'b1, rows: 1, exp_idx: 0, exp_cost: 780300};

    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);

    // Reset state
    check("rst_s_ready", 64'(s_ready), 64'd1);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_best_idx", 64'(best_idx), 64'd0);
    check("rst_best_cost", 64'(best_cost), 64'd0);
    check("rst_m_block_idx", 64'(m_block_idx), 64'd0);

    // Orphan beat after reset: discarded, one-cycle err, stays IDLE
    fill(2, 1);
    pack_row(0);
    send_beat(1'b0, 1'b0, 1'b0, 16'h0001, e);
    check("orphan_err", 64'(e), 64'd1);
    check("orphan_s_ready", 64'(s_ready), 64'd1);
    @(negedge aclk);
    check("orphan_err_cleared", 64'(err), 64'd0);
    check("orphan_no_m_valid", 64'(m_valid), 64'd0);

    // Table of blocks with latency check
    for (int i = 0; i < 7; i++) begin
      fill(vecs[i].kind, vecs[i].rows);
      run_block(vecs[i].rows, vecs[i].md, 16'(16'h0100 + i),
                vecs[i].exp_idx, vecs[i].exp_cost, 1'b0);
      wait_result(lat);
      check("result_latency", 64'(lat), 64'(NC + 1));
      @(negedge aclk);
    end

    // Saturation on the 8-bit accumulator instance
    fill(3, 1);
    run_block(1, 1'b1, 16'h0028, -1, 0, 1'b0);
    n = 0;
    while (!m_valid8 && n < 100) begin
      @(negedge aclk);
      n++;
    end
    check("sat_m_valid8", 64'(m_valid8), 64'd1);
    check("sat_best_cost8", 64'(best_cost8), 64'd255);
    check("sat_best_idx8", 64'(best_idx8), 64'd0);
    @(negedge aclk);

    // Orphan beat after OUTPUT, even with last=1, yields no result
    fill(2, 1);
    pack_row(0);
    send_beat(1'b0, 1'b1, 1'b0, 16'h0002, e);
    check("post_output_orphan_err", 64'(e), 64'd1);
    seen = 1'b0;
    repeat (12) begin
      @(negedge aclk);
      if (m_valid) seen = 1'b1;
    end
    check("post_output_orphan_no_result", 64'(seen), 64'd0);

    // Restart: first=1 while a block is open; result reflects new block only
    fill(2, 1);
    pack_row(0);
    send_beat(1'b1, 1'b0, 1'b0, 16'h0A0A, e);
    check("restart_open_err", 64'(e), 64'd0);
    fill(2, 2);
    run_block(2, 1'b1, 16'h0B0B, -1, 0, 1'b1);
    wait_result(lat);
    @(negedge aclk);

    // Back-pressure: result held stable for 10 cycles
    m_ready = 1'b0;
    fill(2, 2);
    run_block(2, 1'b0, 16'h0029, -1, 0, 1'b0);
    wait_result(lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      check("hold_m_valid", 64'(m_valid), 64'd1);
      check("hold_s_ready", 64'(s_ready), 64'd0);
      check("hold_best_idx", 64'(best_idx), 64'(sb_q[0].idx));
      check("hold_best_cost", 64'(best_cost), 64'(sb_q[0].cost));
      check("hold_m_block_idx", 64'(m_block_idx), 64'(sb_q[0].tag));
    end
    @(posedge aclk);
    #1 m_ready = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    check("release_m_valid", 64'(m_valid), 64'd0);
    check("release_s_ready", 64'(s_ready), 64'd1);

    // Reset in the third COMPUTE cycle discards the block
    fill(2, 2);
    pack_row(0);
    send_beat(1'b1, 1'b0, 1'b0, 16'h3030, e);
    repeat (2) @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check("midrst_m_valid", 64'(m_valid), 64'd0);
    check("midrst_err", 64'(err), 64'd0);
    check("midrst_best_idx", 64'(best_idx), 64'd0);
    check("midrst_best_cost", 64'(best_cost), 64'd0);
    check("midrst_m_block_idx", 64'(m_block_idx), 64'd0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    check("midrst_s_ready", 64'(s_ready), 64'd1);
    seen = 1'b0;
    repeat (15) begin
      @(negedge aclk);
      if (m_valid) seen = 1'b1;
    end
    check("midrst_no_result", 64'(seen), 64'd0);

    // Normal block after the reset
    fill(2, 3);
    run_block(3, 1'b1, 16'h0031, -1, 0, 1'b0);
    wait_result(lat);
    check("post_reset_latency", 64'(lat), 64'(NC + 1));
    @(negedge aclk);

    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge aclk);
      n++;
    end
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
